stage_pipe_reg: RTL and testbench

Parametrised inter-stage pipeline register with valid/ready handshake, a small skid FIFO, and synchronous flush. It replaces the fixed per-stage packed pipe registers between Decode, Execute, MemoryAccess and WriteBack. Any stage payload struct travels as an opaque WIDTH-bit vector, so back-pressure and flush are handled uniformly at every stage boundary instead of ad hoc stall/bubble logic in each stage.

---
 rtl/stage_pipe_reg.sv | 131 +++++++++++++
 tb/tb_stage_pipe_reg.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_pipe_reg.sv
// Inter-stage pipeline register: DEPTH-entry skid FIFO with valid/ready handshake and flush.
// Optional stall/bubble statistics counters are enabled by defining STAGE_PIPE_REG_STAT_EN.
module stage_pipe_reg #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rstN,
    input  logic                         inValid,
    output logic                         inReady,
    input  logic [WIDTH-1:0]             inData,
    output logic                         outValid,
    input  logic                         outReady,
    output logic [WIDTH-1:0]             outData,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef STAGE_PIPE_REG_STAT_EN
    ,
    output logic [31:0]                  stallCycles,
    output logic [31:0]                  bubbleCycles
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [WIDTH-1:0] entry_r [DEPTH];
    logic [PW-1:0]    rd_ptr_r;
    logic [PW-1:0]    wr_ptr_r;
    logic [CW-1:0]    occ_r;
    logic [CW-1:0]    occ_next_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             push_s;
    logic             pop_s;

    // Pointers wrap by compare-and-reset so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] n;
        if (p == LAST_PTR) begin
            n = {PW{1'b0}};
        end else begin
            n = p + PW'(1'b1);
        end
        return n;
    endfunction

    assign push_s    = inValid & in_ready_r & ~flush;
    assign pop_s     = out_valid_r & outReady & ~flush;
    assign inReady   = in_ready_r;
    assign outValid  = out_valid_r;
    assign occupancy = occ_r;
    assign outData   = entry_r[rd_ptr_r];

    // Next occupancy: flush wins, simultaneous push/pop leaves it unchanged.
    always_comb begin
        occ_next_s = occ_r;
        if (flush) begin
            occ_next_s = {CW{1'b0}};
        end else if (push_s && !pop_s) begin
            occ_next_s = occ_r + CW'(1'b1);
        end else if (pop_s && !push_s) begin
            occ_next_s = occ_r - CW'(1'b1);
        end else begin
            occ_next_s = occ_r;
        end
    end

    // Control state; ready/valid are registered copies derived from next occupancy.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            occ_r       <= {CW{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            rd_ptr_r    <= {PW{1'b0}};
            wr_ptr_r    <= {PW{1'b0}};
        end else begin
            occ_r       <= occ_next_s;
            in_ready_r  <= (occ_next_s < DEPTH_C);
            out_valid_r <= (occ_next_s != {CW{1'b0}});
            if (flush) begin
                rd_ptr_r <= {PW{1'b0}};
                wr_ptr_r <= {PW{1'b0}};
            end else begin
                if (push_s) begin
                    wr_ptr_r <= ptr_inc(wr_ptr_r);
                end
                if (pop_s) begin
                    rd_ptr_r <= ptr_inc(rd_ptr_r);
                end
            end
        end
    end

    // Payload storage; flush leaves contents untouched since push is masked.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push_s) begin
            entry_r[wr_ptr_r] <= inData;
        end
    end

`ifdef STAGE_PIPE_REG_STAT_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] bubble_cnt_r;

    assign stallCycles  = stall_cnt_r;
    assign bubbleCycles = bubble_cnt_r;

    // Saturating statistics; intentionally survive flush.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            stall_cnt_r  <= 32'd0;
            bubble_cnt_r <= 32'd0;
        end else begin
            if (inValid && !in_ready_r && !flush && (stall_cnt_r != 32'hFFFF_FFFF)) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end
            if (!out_valid_r && outReady && (bubble_cnt_r != 32'hFFFF_FFFF)) begin
                bubble_cnt_r <= bubble_cnt_r + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_stage_pipe_reg.sv
// Self-checking bench for stage_pipe_reg: DEPTH=2 and DEPTH=3 instances against a queue model.
module tb_stage_pipe_reg;
    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
    logic [W-1:0] a_in_data, a_out_data;
    logic [1:0]   a_occ;
    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
    logic [W-1:0] b_in_data, b_out_data;
    logic [1:0]   b_occ;
`ifdef STAGE_PIPE_REG_STAT_EN
    logic [31:0]  a_stall, a_bubble, b_stall, b_bubble;
`endif

    stage_pipe_reg #(.WIDTH(W), .DEPTH(2)) dut_a (
        .clk(clk), .rstN(rst_n),
        .inValid(a_in_valid), .inReady(a_in_ready), .inData(a_in_data),
        .outValid(a_out_valid), .outReady(a_out_ready), .outData(a_out_data),
        .flush(a_flush), .occupancy(a_occ)
`ifdef STAGE_PIPE_REG_STAT_EN
        , .stallCycles(a_stall), .bubbleCycles(a_bubble)
`endif
    );

    stage_pipe_reg #(.WIDTH(W), .DEPTH(3)) dut_b (
        .clk(clk), .rstN(rst_n),
        .inValid(b_in_valid), .inReady(b_in_ready), .inData(b_in_data),
        .outValid(b_out_valid), .outReady(b_out_ready), .outData(b_out_data),
        .flush(b_flush), .occupancy(b_occ)
`ifdef STAGE_PIPE_REG_STAT_EN
        , .stallCycles(b_stall), .bubbleCycles(b_bubble)
`endif
    );

    int n_checks = 0;
    int n_fail = 0;
    logic [W-1:0] q_a[$];
    logic [W-1:0] q_b[$];
    logic [W-1:0] obs_a[$];

    // One cycle on instance A; the reference is an ideal FIFO with capacity 2.
    task automatic step_a(input logic v, input logic [W-1:0] d, input logic r, input logic f);
        bit push, pop;
        logic [W-1:0] tmp;
        a_in_valid = v; a_in_data = d; a_out_ready = r; a_flush = f;
        push = v && (q_a.size() < 2) && !f;
        pop  = (q_a.size() != 0) && r && !f;
        if (a_out_valid && r && !f) obs_a.push_back(a_out_data);
        @(posedge clk);
        if (f) begin
            q_a.delete();
        end else begin
            if (pop) tmp = q_a.pop_front();
            if (push) q_a.push_back(d);
        end
        #1;
    endtask

    // One cycle on instance B; ideal FIFO with capacity 3.
    task automatic step_b(input logic v, input logic [W-1:0] d, input logic r, input logic f);
        bit push, pop;
        logic [W-1:0] tmp;
        b_in_valid = v; b_in_data = d; b_out_ready = r; b_flush = f;
        push = v && (q_b.size() < 3) && !f;
        pop  = (q_b.size() != 0) && r && !f;
        @(posedge clk);
        if (f) begin
            q_b.delete();
        end else begin
            if (pop) tmp = q_b.pop_front();
            if (push) q_b.push_back(d);
        end
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0; a_flush = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0; b_flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_occ !== 2'd0 || a_out_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: ready=%b valid=%b occ=%0d data=%h, required 1 0 0 0", a_in_ready, a_out_valid, a_occ, a_out_data);
        end
        n_checks++;
        if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0 || b_occ !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state_b: ready=%b valid=%b occ=%0d, required 1 0 0", b_in_ready, b_out_valid, b_occ);
        end
`ifdef STAGE_PIPE_REG_STAT_EN
        n_checks++;
        if (a_stall !== 32'd0 || a_bubble !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_stats: stall=%0d bubble=%0d, required 0 0", a_stall, a_bubble);
        end
`endif
        rst_n = 1'b1;
        step_a(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        n_checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== 32'hDEAD_BEEF || a_occ !== 2'd1) begin
            n_fail++;
            $display("FAIL single_push: valid=%b data=%h occ=%0d, required 1 deadbeef 1", a_out_valid, a_out_data, a_occ);
        end
        step_a(1'b0, '0, 1'b1, 1'b0);
        n_checks++;
        if (a_out_valid !== 1'b0 || a_occ !== 2'd0) begin
            n_fail++;
            $display("FAIL single_drain: valid=%b occ=%0d, required 0 0", a_out_valid, a_occ);
        end
    endtask

    task automatic test_fill_backpressure;
`ifdef STAGE_PIPE_REG_STAT_EN
        logic [31:0] stall0 = a_stall;
`endif
        obs_a.delete();
        step_a(1'b1, 32'd1, 1'b0, 1'b0);
        step_a(1'b1, 32'd2, 1'b0, 1'b0);
        n_checks++;
        if (a_in_ready !== 1'b0 || a_occ !== 2'd2) begin
            n_fail++;
            $display("FAIL fill_full: ready=%b occ=%0d, required 0 2", a_in_ready, a_occ);
        end
        step_a(1'b1, 32'd3, 1'b0, 1'b0);
        n_checks++;
        if (a_in_ready !== 1'b0 || a_occ !== 2'd2 || a_out_data !== 32'd1) begin
            n_fail++;
            $display("FAIL fill_hold: ready=%b occ=%0d data=%0d, required 0 2 1", a_in_ready, a_occ, a_out_data);
        end
        for (int k = 0; k < 3; k++) begin
            step_a(k < 2, 32'd3, 1'b1, 1'b0);
            n_checks++;
            if (a_occ !== 2'(q_a.size()) || a_occ > 2'd2) begin
                n_fail++;
                $display("FAIL fill_drain_occ: cycle %0d occ=%0d, required %0d", k, a_occ, q_a.size());
            end
        end
        n_checks++;
        if (obs_a.size() != 3 || obs_a[0] !== 32'd1 || obs_a[1] !== 32'd2 || obs_a[2] !== 32'd3) begin
            n_fail++;
            $display("FAIL fill_order: got %0d items, required 1 2 3", obs_a.size());
        end
`ifdef STAGE_PIPE_REG_STAT_EN
        n_checks++;
        if (a_stall - stall0 !== 32'd2) begin
            n_fail++;
            $display("FAIL fill_stall_count: got %0d, required 2", a_stall - stall0);
        end
`endif
    endtask

    task automatic test_streaming;
        int bad = 0;
`ifdef STAGE_PIPE_REG_STAT_EN
        logic [31:0] stall0 = a_stall;
        logic [31:0] bubble0 = a_bubble;
`endif
        obs_a.delete();
        for (int i = 0; i < 100; i++) begin
            step_a(1'b1, 32'(i), 1'b1, 1'b0);
            n_checks++;
            if (a_out_valid !== 1'b1 || a_out_data !== 32'(i) || a_occ !== 2'd1 || a_in_ready !== 1'b1) begin
                n_fail++;
                bad++;
                if (bad < 5) $display("FAIL stream_cycle: i=%0d valid=%b data=%0d occ=%0d, required 1 %0d 1", i, a_out_valid, a_out_data, a_occ, i);
            end
        end
        step_a(1'b0, '0, 1'b1, 1'b0);
        step_a(1'b0, '0, 1'b0, 1'b0);
        n_checks++;
        if (obs_a.size() != 100 || a_occ !== 2'd0) begin
            n_fail++;
            $display("FAIL stream_count: got %0d items occ=%0d, required 100 0", obs_a.size(), a_occ);
        end
        for (int i = 0; i < obs_a.size(); i++) begin
            n_checks++;
            if (obs_a[i] !== 32'(i)) begin
                n_fail++;
                $display("FAIL stream_order: idx %0d got %0d, required %0d", i, obs_a[i], i);
            end
        end
`ifdef STAGE_PIPE_REG_STAT_EN
        n_checks++;
        if (a_stall - stall0 !== 32'd0 || a_bubble - bubble0 !== 32'd1) begin
            n_fail++;
            $display("FAIL stream_stats: stall=%0d bubble=%0d, required 0 1", a_stall - stall0, a_bubble - bubble0);
        end
`endif
    endtask

    task automatic test_flush;
        step_a(1'b1, 32'd5, 1'b0, 1'b0);
        step_a(1'b1, 32'd6, 1'b0, 1'b0);
        n_checks++;
        if (a_occ !== 2'd2) begin
            n_fail++;
            $display("FAIL flush_prefill: occ=%0d, required 2", a_occ);
        end
        obs_a.delete();
        step_a(1'b1, 32'd7, 1'b1, 1'b1);
        n_checks++;
        if (a_occ !== 2'd0 || a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_state: occ=%0d valid=%b ready=%b, required 0 0 1", a_occ, a_out_valid, a_in_ready);
        end
        step_a(1'b1, 32'd8, 1'b0, 1'b0);
        n_checks++;
        if (a_occ !== 2'd1 || a_out_valid !== 1'b1 || a_out_data !== 32'd8) begin
            n_fail++;
            $display("FAIL flush_repush: occ=%0d valid=%b data=%0d, required 1 1 8", a_occ, a_out_valid, a_out_data);
        end
        step_a(1'b0, '0, 1'b1, 1'b0);
        step_a(1'b0, '0, 1'b0, 1'b0);
        n_checks++;
        if (obs_a.size() != 1 || obs_a[0] !== 32'd8) begin
            n_fail++;
            $display("FAIL flush_output: got %0d items first=%0d, required only 8", obs_a.size(), obs_a.size() ? obs_a[0] : 32'd0);
        end
    endtask

    task automatic test_wrap_depth3;
        int bad = 0;
        int pops = 0;
        for (int c = 0; c < 120; c++) begin
            logic v, r, f;
            v = ($urandom_range(0, 3) != 0);
            r = (c < 20) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
            f = ($urandom_range(0, 29) == 0);
            if (b_out_valid && r && !f) pops++;
            step_b(v, $urandom, r, f);
            n_checks++;
            if (b_occ !== 2'(q_b.size()) || b_occ > 2'd3 || b_out_valid !== (q_b.size() != 0) ||
                b_in_ready !== (q_b.size() < 3) || (q_b.size() != 0 && b_out_data !== q_b[0])) begin
                n_fail++;
                bad++;
                if (bad < 5) $display("FAIL wrap3: cycle %0d occ=%0d valid=%b data=%h, required occ %0d", c, b_occ, b_out_valid, b_out_data, q_b.size());
            end
        end
        n_checks++;
        if (pops < 10) begin
            n_fail++;
            $display("FAIL wrap3_activity: pops=%0d, required at least 10", pops);
        end
    endtask

    task automatic test_async_reset;
        step_a(1'b1, 32'd11, 1'b0, 1'b0);
        step_a(1'b1, 32'd12, 1'b0, 1'b0);
        a_in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (a_out_valid !== 1'b0 || a_occ !== 2'd0 || a_in_ready !== 1'b1 || a_out_data !== 32'd0) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b occ=%0d ready=%b data=%h, required 0 0 1 0", a_out_valid, a_occ, a_in_ready, a_out_data);
        end
        q_a.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step_a(1'b1, 32'd42, 1'b0, 1'b0);
        n_checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== 32'd42 || a_occ !== 2'd1) begin
            n_fail++;
            $display("FAIL post_reset_push: valid=%b data=%0d occ=%0d, required 1 42 1", a_out_valid, a_out_data, a_occ);
        end
    endtask

    initial begin
        test_reset();
        test_fill_backpressure();
        test_streaming();
        test_flush();
        test_wrap_depth3();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
